pupil_region_extractor: RTL and testbench

- Stream sink at the output of the closing stage (dilation followed by erosion). It reads the filtered raster pixel stream (data_in with data_valid) and tracks each pixel's column/row position.
- It classifies pupil (dark) pixels and accumulates per-frame pupil statistics: bounding box, pixel count and box centre.
- At frame end it publishes one registered result with a single-cycle valid pulse for downstream pupil-location logic.

---
 rtl/pupil_region_extractor_if.sv | 32 +++
 rtl/pupil_region_extractor.sv | 170 +++++++++++++++++
 tb/tb_pupil_region_extractor.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/pupil_region_extractor_if.sv
// Pixel stream and per-frame pupil result bundle between the closing stage,
// the extractor and the downstream pupil-location logic.
interface pupil_region_extractor_if #(
    parameter int data_width  = 8,
    parameter int coord_width = 9,
    parameter int count_width = 17
);
    logic                   data_valid;
    logic [data_width-1:0]  data_in;
    logic [coord_width-1:0] x_min;
    logic [coord_width-1:0] x_max;
    logic [coord_width-1:0] y_min;
    logic [coord_width-1:0] y_max;
    logic [coord_width-1:0] centre_x;
    logic [coord_width-1:0] centre_y;
    logic [count_width-1:0] pixel_count;
    logic                   pupil_found;
    logic                   result_valid;
    logic                   busy;

    modport master (
        output data_valid, data_in,
        input  x_min, x_max, y_min, y_max, centre_x, centre_y,
        input  pixel_count, pupil_found, result_valid, busy
    );

    modport slave (
        input  data_valid, data_in,
        output x_min, x_max, y_min, y_max, centre_x, centre_y,
        output pixel_count, pupil_found, result_valid, busy
    );
endinterface

// File: rtl/pupil_region_extractor.sv
// Tracks raster position of a filtered pixel stream, accumulates the bounding
// box and count of dark (pupil) pixels and publishes one result per frame.
module pupil_region_extractor #(
    parameter int data_width  = 8,
    parameter int img_width   = 317,
    parameter int img_height  = 317,
    parameter int coord_width = 9,
    parameter int count_width = 17,
    parameter int threshold   = 128
) (
    input logic                    clock,
    input logic                    rst_n,
    pupil_region_extractor_if.slave bus
);
    typedef enum logic [0:0] {ACCUM = 1'b0, REPORT = 1'b1} state_t;

    localparam logic [coord_width-1:0] last_col  = coord_width'(img_width - 1);
    localparam logic [coord_width-1:0] last_row  = coord_width'(img_height - 1);
    localparam logic [data_width-1:0]  thresh    = data_width'(threshold);

    state_t                 state_r, state_nxt_s;
    logic [coord_width-1:0] col_r, row_r, col_nxt_s, row_nxt_s;
    logic [coord_width-1:0] acc_xmin_r, acc_xmax_r, acc_ymin_r, acc_ymax_r;
    logic [count_width-1:0] acc_cnt_r;
    logic [coord_width-1:0] base_xmin_s, base_xmax_s, base_ymin_s, base_ymax_s;
    logic [count_width-1:0] base_cnt_s;
    logic [coord_width-1:0] acc_xmin_nxt_s, acc_xmax_nxt_s, acc_ymin_nxt_s, acc_ymax_nxt_s;
    logic [count_width-1:0] acc_cnt_nxt_s;
    logic [coord_width:0]   sum_x_s, sum_y_s;
    logic                   is_pupil_s, take_s, last_pixel_s;

    logic [coord_width-1:0] x_min_r, x_max_r, y_min_r, y_max_r, centre_x_r, centre_y_r;
    logic [count_width-1:0] pixel_count_r;
    logic                   pupil_found_r, result_valid_r, busy_r;

    // Raster position, classification and next-frame state.
    always_comb begin
        col_nxt_s    = col_r;
        row_nxt_s    = row_r;
        state_nxt_s  = state_r;
        is_pupil_s   = (bus.data_in < thresh);
        take_s       = bus.data_valid && is_pupil_s;
        last_pixel_s = bus.data_valid && (col_r == last_col) && (row_r == last_row);
        if (bus.data_valid) begin
            if (col_r == last_col) begin
                col_nxt_s = '0;
                row_nxt_s = (row_r == last_row) ? '0 : row_r + coord_width'(1);
            end else begin
                col_nxt_s = col_r + coord_width'(1);
                row_nxt_s = row_r;
            end
        end else begin
            col_nxt_s = col_r;
            row_nxt_s = row_r;
        end
        case (state_r)
            ACCUM:   state_nxt_s = last_pixel_s ? REPORT : ACCUM;
            REPORT:  state_nxt_s = last_pixel_s ? REPORT : ACCUM;
            default: state_nxt_s = ACCUM;
        endcase
    end

    // Accumulators restart from their init values in REPORT, so a pixel
    // arriving in that cycle is folded into the fresh frame.
    always_comb begin
        base_xmin_s = (state_r == REPORT) ? '1 : acc_xmin_r;
        base_xmax_s = (state_r == REPORT) ? '0 : acc_xmax_r;
        base_ymin_s = (state_r == REPORT) ? '1 : acc_ymin_r;
        base_ymax_s = (state_r == REPORT) ? '0 : acc_ymax_r;
        base_cnt_s  = (state_r == REPORT) ? '0 : acc_cnt_r;
        if (take_s) begin
            acc_xmin_nxt_s = (col_r < base_xmin_s) ? col_r : base_xmin_s;
            acc_xmax_nxt_s = (col_r > base_xmax_s) ? col_r : base_xmax_s;
            acc_ymin_nxt_s = (row_r < base_ymin_s) ? row_r : base_ymin_s;
            acc_ymax_nxt_s = (row_r > base_ymax_s) ? row_r : base_ymax_s;
            acc_cnt_nxt_s  = (base_cnt_s == '1) ? base_cnt_s : base_cnt_s + count_width'(1);
        end else begin
            acc_xmin_nxt_s = base_xmin_s;
            acc_xmax_nxt_s = base_xmax_s;
            acc_ymin_nxt_s = base_ymin_s;
            acc_ymax_nxt_s = base_ymax_s;
            acc_cnt_nxt_s  = base_cnt_s;
        end
        sum_x_s = {1'b0, acc_xmin_nxt_s} + {1'b0, acc_xmax_nxt_s};
        sum_y_s = {1'b0, acc_ymin_nxt_s} + {1'b0, acc_ymax_nxt_s};
    end

    // State, position and accumulator registers.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_r    <= ACCUM;
            col_r      <= '0;
            row_r      <= '0;
            acc_xmin_r <= '1;
            acc_xmax_r <= '0;
            acc_ymin_r <= '1;
            acc_ymax_r <= '0;
            acc_cnt_r  <= '0;
        end else begin
            state_r    <= state_nxt_s;
            col_r      <= col_nxt_s;
            row_r      <= row_nxt_s;
            acc_xmin_r <= acc_xmin_nxt_s;
            acc_xmax_r <= acc_xmax_nxt_s;
            acc_ymin_r <= acc_ymin_nxt_s;
            acc_ymax_r <= acc_ymax_nxt_s;
            acc_cnt_r  <= acc_cnt_nxt_s;
        end
    end

    // Result registers load on the last-pixel edge so they are valid in REPORT.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            x_min_r        <= '0;
            x_max_r        <= '0;
            y_min_r        <= '0;
            y_max_r        <= '0;
            centre_x_r     <= '0;
            centre_y_r     <= '0;
            pixel_count_r  <= '0;
            pupil_found_r  <= 1'b0;
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            result_valid_r <= last_pixel_s;
            busy_r         <= (col_nxt_s != '0) || (row_nxt_s != '0);
            if (last_pixel_s) begin
                if (acc_cnt_nxt_s != '0) begin
                    x_min_r       <= acc_xmin_nxt_s;
                    x_max_r       <= acc_xmax_nxt_s;
                    y_min_r       <= acc_ymin_nxt_s;
                    y_max_r       <= acc_ymax_nxt_s;
                    centre_x_r    <= coord_width'(sum_x_s >> 1);
                    centre_y_r    <= coord_width'(sum_y_s >> 1);
                    pixel_count_r <= acc_cnt_nxt_s;
                    pupil_found_r <= 1'b1;
                end else begin
                    x_min_r       <= '0;
                    x_max_r       <= '0;
                    y_min_r       <= '0;
                    y_max_r       <= '0;
                    centre_x_r    <= '0;
                    centre_y_r    <= '0;
                    pixel_count_r <= '0;
                    pupil_found_r <= 1'b0;
                end
            end else begin
                x_min_r       <= x_min_r;
                x_max_r       <= x_max_r;
                y_min_r       <= y_min_r;
                y_max_r       <= y_max_r;
                centre_x_r    <= centre_x_r;
                centre_y_r    <= centre_y_r;
                pixel_count_r <= pixel_count_r;
                pupil_found_r <= pupil_found_r;
            end
        end
    end

    assign bus.x_min        = x_min_r;
    assign bus.x_max        = x_max_r;
    assign bus.y_min        = y_min_r;
    assign bus.y_max        = y_max_r;
    assign bus.centre_x     = centre_x_r;
    assign bus.centre_y     = centre_y_r;
    assign bus.pixel_count  = pixel_count_r;
    assign bus.pupil_found  = pupil_found_r;
    assign bus.result_valid = result_valid_r;
    assign bus.busy         = busy_r;
endmodule

// File: tb/tb_pupil_region_extractor.sv
// Bench for pupil_region_extractor on a 4x3 image: frame-level reference
// model compared every cycle, plus literal checks of the directed frames.
module tb_pupil_region_extractor;
    localparam int W = 4, H = 3, N = W * H, DW = 8, CW = 9, KW = 17, TH = 128;

    typedef struct {
        int xmin, xmax, ymin, ymax, cx, cy, cnt, found;
    } res_t;

    logic clock = 1'b0;
    logic rst_n = 1'b0;

    pupil_region_extractor_if #(.data_width(DW), .coord_width(CW), .count_width(KW)) bus ();

    pupil_region_extractor #(
        .data_width(DW), .img_width(W), .img_height(H),
        .coord_width(CW), .count_width(KW), .threshold(TH)
    ) u_dut (
        .clock(clock),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;
    int pulses   = 0;
    res_t caps[$];

    // model state: frame-level view of the stream
    int   m_idx = 0;
    int   m_pix[N];
    res_t e;
    int   e_rv = 0, e_busy = 0;
    bit   ready = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic eval_frame();
        int c, xmn, xmx, ymn, ymx;
        c = 0; xmn = 1 << 30; xmx = -1; ymn = 1 << 30; ymx = -1;
        for (int i = 0; i < N; i++) begin
            if (m_pix[i] < TH) begin
                c++;
                if (i % W < xmn) xmn = i % W;
                if (i % W > xmx) xmx = i % W;
                if (i / W < ymn) ymn = i / W;
                if (i / W > ymx) ymx = i / W;
            end
        end
        if (c == 0) e = '{0, 0, 0, 0, 0, 0, 0, 0};
        else        e = '{xmn, xmx, ymn, ymx, (xmn + xmx) / 2, (ymn + ymx) / 2, c, 1};
    endtask

    // compare at negedge, then predict what the next posedge produces
    initial begin
        e = '{0, 0, 0, 0, 0, 0, 0, 0};
        forever begin
            @(negedge clock);
            if (ready) begin
                chk("result_valid", int'(bus.result_valid), e_rv);
                chk("busy", int'(bus.busy), e_busy);
                chk("x_min", int'(bus.x_min), e.xmin);
                chk("x_max", int'(bus.x_max), e.xmax);
                chk("y_min", int'(bus.y_min), e.ymin);
                chk("y_max", int'(bus.y_max), e.ymax);
                chk("centre_x", int'(bus.centre_x), e.cx);
                chk("centre_y", int'(bus.centre_y), e.cy);
                chk("pixel_count", int'(bus.pixel_count), e.cnt);
                chk("pupil_found", int'(bus.pupil_found), e.found);
                if (bus.result_valid === 1'b1) begin
                    pulses++;
                    caps.push_back('{int'(bus.x_min), int'(bus.x_max), int'(bus.y_min),
                                     int'(bus.y_max), int'(bus.centre_x), int'(bus.centre_y),
                                     int'(bus.pixel_count), int'(bus.pupil_found)});
                end
            end
            if (!rst_n) begin
                m_idx = 0;
                e_rv  = 0;
                e     = '{0, 0, 0, 0, 0, 0, 0, 0};
            end else begin
                e_rv = 0;
                if (bus.data_valid) begin
                    m_pix[m_idx] = int'(bus.data_in);
                    if (m_idx == N - 1) begin
                        eval_frame();
                        e_rv  = 1;
                        m_idx = 0;
                    end else begin
                        m_idx++;
                    end
                end
            end
            e_busy = (m_idx != 0) ? 1 : 0;
            ready  = 1'b1;
        end
    end

    task automatic drive_pix(input logic [DW-1:0] v);
        bus.data_valid = 1'b1;
        bus.data_in    = v;
        @(posedge clock); #1;
    endtask

    task automatic idle(input int n);
        bus.data_valid = 1'b0;
        bus.data_in    = DW'($urandom);
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    function automatic logic [DW-1:0] pix_val(input int kind, input int i);
        int c, r;
        c = i % W; r = i / W;
        case (kind)
            0: return 8'd255;
            1: return (c == 2 && r == 1) ? 8'd10 : 8'd200;
            2: return (c >= 1) ? 8'd0 : 8'd255;
            3: return 8'd128;
            4: return 8'd127;
            5: return (c == 3 && r == 2) ? 8'd0 : 8'd255;
            default: begin
                case ($urandom_range(0, 5))
                    0, 1: return 8'($urandom_range(0, TH - 1));
                    2:    return 8'd127;
                    3:    return 8'd128;
                    default: return 8'($urandom_range(TH, 255));
                endcase
            end
        endcase
    endfunction

    task automatic send_frame(input int kind, input bit toggle);
        for (int i = 0; i < N; i++) begin
            drive_pix(pix_val(kind, i));
            if (toggle) idle(1);
            else if (kind == 6 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
    endtask

    task automatic chk_res(input string tag, input res_t r, input res_t x);
        chk({tag, "_xmin"}, r.xmin, x.xmin);
        chk({tag, "_xmax"}, r.xmax, x.xmax);
        chk({tag, "_ymin"}, r.ymin, x.ymin);
        chk({tag, "_ymax"}, r.ymax, x.ymax);
        chk({tag, "_cx"}, r.cx, x.cx);
        chk({tag, "_cy"}, r.cy, x.cy);
        chk({tag, "_cnt"}, r.cnt, x.cnt);
        chk({tag, "_found"}, r.found, x.found);
    endtask

    task automatic last_res(output res_t r);
        if (caps.size() > 0) r = caps[caps.size() - 1];
        else                 r = '{-1, -1, -1, -1, -1, -1, -1, -1};
    endtask

    initial begin
        int   p0;
        res_t r, ra;
        bus.data_valid = 1'b0;
        bus.data_in    = '0;
        repeat (2) @(posedge clock);
        #1 rst_n = 1'b1;
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_count", int'(bus.pixel_count), 0);

        p0 = pulses; send_frame(0, 1'b0); idle(3);
        chk("t1_pulses", pulses - p0, 1);
        last_res(r); chk_res("t1", r, '{0, 0, 0, 0, 0, 0, 0, 0});

        send_frame(1, 1'b0); idle(3);
        last_res(r); chk_res("t2", r, '{2, 2, 1, 1, 2, 1, 1, 1});

        send_frame(2, 1'b0); idle(3);
        last_res(ra);
        send_frame(2, 1'b1); idle(3);
        last_res(r); chk_res("t3", r, '{1, 3, 0, 2, 2, 1, 9, 1});
        chk_res("t3_same", r, ra);

        p0 = pulses; send_frame(3, 1'b0); send_frame(4, 1'b0); idle(3);
        chk("t4_pulses", pulses - p0, 2);
        if (caps.size() >= 2) begin
            chk_res("t4_f1", caps[caps.size() - 2], '{0, 0, 0, 0, 0, 0, 0, 0});
            chk_res("t4_f2", caps[caps.size() - 1], '{0, 3, 0, 2, 1, 1, 12, 1});
        end

        p0 = pulses;
        repeat (5) drive_pix(8'd0);
        bus.data_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clock); #1;
        rst_n = 1'b1;
        chk("t5_busy", int'(bus.busy), 0);
        chk("t5_cleared", int'(bus.pixel_count), 0);
        send_frame(5, 1'b0); idle(3);
        chk("t5_pulses", pulses - p0, 1);
        last_res(r); chk_res("t5", r, '{3, 3, 2, 2, 3, 2, 1, 1});

        p0 = pulses;
        for (int f = 0; f < 10; f++) begin
            send_frame(6, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
        end
        idle(3);
        chk("t6_pulses", pulses - p0, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
